bus_b_mux_reg: RTL and testbench

Parametrised, registered successor to the processor's B-bus source multiplexer. It selects one of `NUM_SRC` register/memory sources onto the B bus. Sources flagged as narrow, such as RAM data or instruction bytes, are zero-extended. The selected value is registered behind a one-cycle valid strobe. Out-of-range selects are handled deterministically: the bus holds its value, a sticky error flag is raised, and a saturating error counter increments. The block sits between the register file/RAM outputs and the ALU B-operand and register-load paths, and is driven by the control unit.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_src_extend.sv | 21 ++
 rtl/bus_b_mux_reg.sv | 124 ++++++++++++
 tb/tb_bus_b_mux_reg.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants for the B-bus source multiplexer: default widths,
// named source indices and the default narrow-source mask.
package bus_pkg;

  localparam int BUS_DATA_W   = 16;
  localparam int BUS_NARROW_W = 8;
  localparam int BUS_NUM_SRC  = 9;

  localparam int SRC_RAM   = 0;
  localparam int SRC_PC    = 1;
  localparam int SRC_R1    = 2;
  localparam int SRC_R2    = 3;
  localparam int SRC_TR    = 4;
  localparam int SRC_R     = 5;
  localparam int SRC_AC    = 6;
  localparam int SRC_INSTR = 7;
  localparam int SRC_AR    = 8;

  // RAM data and instruction bytes are the narrow sources.
  localparam logic [BUS_NUM_SRC-1:0] BUS_NARROW_MASK = 9'b0_1000_0001;

endpackage

// File: rtl/bus_src_extend.sv
// Combinational zero-extension of one bus source; wide sources pass through.
module bus_src_extend
  import bus_pkg::*;
#(
  parameter int DATA_W   = BUS_DATA_W,
  parameter int NARROW_W = BUS_NARROW_W,
  parameter bit NARROW   = 1'b0
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  localparam logic [DATA_W-1:0] KEEP_MASK =
    NARROW ? {{(DATA_W-NARROW_W){1'b0}}, {NARROW_W{1'b1}}} : {DATA_W{1'b1}};

  // Mask off the upper bits of a narrow source.
  always_comb begin
    o_data = i_data & KEEP_MASK;
  end

endmodule

// File: rtl/bus_b_mux_reg.sv
// Registered B-bus source multiplexer with out-of-range select detection,
// a sticky error flag and a saturating error counter.
module bus_b_mux_reg
  import bus_pkg::*;
#(
  parameter int                   NUM_SRC     = BUS_NUM_SRC,
  parameter int                   DATA_W      = BUS_DATA_W,
  parameter int                   NARROW_W    = BUS_NARROW_W,
  parameter logic [NUM_SRC-1:0]   NARROW_MASK = BUS_NARROW_MASK,
  parameter int                   SEL_W       = 4,
  parameter int                   ERRCNT_W    = 8
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        SEL_VALID,
  input  logic [SEL_W-1:0]            SELECT,
  input  logic [NUM_SRC*DATA_W-1:0]   SRC_DATA,
  input  logic                        ERR_CLR,
  output logic [DATA_W-1:0]           BUS,
  output logic                        BUS_VALID,
  output logic [SEL_W-1:0]            LAST_SEL,
  output logic                        SEL_ERR,
  output logic [ERRCNT_W-1:0]         ERR_CNT
);

  // Extra bit lets NUM_SRC == 2**SEL_W compare correctly.
  localparam logic [SEL_W:0]      NSRC_EXT = (SEL_W+1)'(NUM_SRC);
  localparam logic [ERRCNT_W-1:0] ERR_MAX  = {ERRCNT_W{1'b1}};

  logic [DATA_W-1:0]   w_ext [NUM_SRC];
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_in_range;
  logic                w_load;
  logic                w_invalid;
  logic                w_sel_err_nxt;
  logic [ERRCNT_W-1:0] w_err_cnt_nxt;

  logic [DATA_W-1:0]   r_bus;
  logic                r_bus_valid;
  logic [SEL_W-1:0]    r_last_sel;
  logic                r_sel_err;
  logic [ERRCNT_W-1:0] r_err_cnt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_ext
    bus_src_extend #(
      .DATA_W   (DATA_W),
      .NARROW_W (NARROW_W),
      .NARROW   (NARROW_MASK[g])
    ) u_ext (
      .i_data (SRC_DATA[g*DATA_W +: DATA_W]),
      .o_data (w_ext[g])
    );
  end

  // One-hot AND-OR select; never indexes outside the source array.
  always_comb begin
    w_sel_data = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      w_sel_data = w_sel_data | ({DATA_W{SELECT == SEL_W'(i)}} & w_ext[i]);
    end
  end

  // Request classification.
  always_comb begin
    w_in_range = ({1'b0, SELECT} < NSRC_EXT);
    w_load     = SEL_VALID & w_in_range;
    w_invalid  = SEL_VALID & ~w_in_range;
  end

  // Error flag and counter next state; an invalid request beats a clear.
  always_comb begin
    w_sel_err_nxt = r_sel_err;
    w_err_cnt_nxt = r_err_cnt;
    if (w_invalid) begin
      w_sel_err_nxt = 1'b1;
      if (ERR_CLR) begin
        w_err_cnt_nxt = {{(ERRCNT_W-1){1'b0}}, 1'b1};
      end else if (r_err_cnt != ERR_MAX) begin
        w_err_cnt_nxt = r_err_cnt + {{(ERRCNT_W-1){1'b0}}, 1'b1};
      end else begin
        w_err_cnt_nxt = r_err_cnt;
      end
    end else if (ERR_CLR) begin
      w_sel_err_nxt = 1'b0;
      w_err_cnt_nxt = {ERRCNT_W{1'b0}};
    end else begin
      w_sel_err_nxt = r_sel_err;
      w_err_cnt_nxt = r_err_cnt;
    end
  end

  // Bus data path register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_bus       <= {DATA_W{1'b0}};
      r_bus_valid <= 1'b0;
      r_last_sel  <= {SEL_W{1'b0}};
    end else begin
      r_bus_valid <= w_load;
      if (w_load) begin
        r_bus      <= w_sel_data;
        r_last_sel <= SELECT;
      end
    end
  end

  // Error status register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sel_err <= 1'b0;
      r_err_cnt <= {ERRCNT_W{1'b0}};
    end else begin
      r_sel_err <= w_sel_err_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  assign BUS       = r_bus;
  assign BUS_VALID = r_bus_valid;
  assign LAST_SEL  = r_last_sel;
  assign SEL_ERR   = r_sel_err;
  assign ERR_CNT   = r_err_cnt;

endmodule

// File: tb/tb_bus_b_mux_reg.sv
// Directed self-checking bench for bus_b_mux_reg with hand-computed expectations.
module tb_bus_b_mux_reg;
  import bus_pkg::*;

  logic          CLK;
  logic          RST_N;
  logic          SEL_VALID;
  logic [3:0]    SELECT;
  logic [143:0]  SRC_DATA;
  logic          ERR_CLR;
  logic [15:0]   BUS;
  logic          BUS_VALID;
  logic [3:0]    LAST_SEL;
  logic          SEL_ERR;
  logic [7:0]    ERR_CNT;

  logic [15:0]   src [9];
  int            n_vec;
  int            n_err;

  bus_b_mux_reg dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SEL_VALID (SEL_VALID),
    .SELECT    (SELECT),
    .SRC_DATA  (SRC_DATA),
    .ERR_CLR   (ERR_CLR),
    .BUS       (BUS),
    .BUS_VALID (BUS_VALID),
    .LAST_SEL  (LAST_SEL),
    .SEL_ERR   (SEL_ERR),
    .ERR_CNT   (ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    for (int i = 0; i < 9; i++) SRC_DATA[i*16 +: 16] = src[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one request across a rising edge, then settle to the falling edge.
  task automatic step(input logic v, input logic [3:0] s, input logic clr);
    SEL_VALID = v;
    SELECT    = s;
    ERR_CLR   = clr;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_all(input string tag, input logic [15:0] bus, input logic vld,
                           input logic [3:0] last, input logic err, input logic [7:0] cnt);
    check({tag, ".bus"},  32'(BUS),       32'(bus));
    check({tag, ".vld"},  32'(BUS_VALID), 32'(vld));
    check({tag, ".last"}, 32'(LAST_SEL),  32'(last));
    check({tag, ".err"},  32'(SEL_ERR),   32'(err));
    check({tag, ".cnt"},  32'(ERR_CNT),   32'(cnt));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    SEL_VALID = 1'b0;
    SELECT    = 4'd0;
    ERR_CLR   = 1'b0;
    src[SRC_RAM]   = 16'hABCD;
    src[SRC_PC]    = 16'hC0DE;
    src[SRC_R1]    = 16'h2468;
    src[SRC_R2]    = 16'h1357;
    src[SRC_TR]    = 16'h1111;
    src[SRC_R]     = 16'h1234;
    src[SRC_AC]    = 16'h5A5A;
    src[SRC_INSTR] = 16'hBEEF;
    src[SRC_AR]    = 16'h0F0F;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #2 check_all("reset0", 16'h0000, 1'b0, 4'd0, 1'b0, 8'd0);
    @(negedge CLK) RST_N = 1'b1;

    step(1'b1, 4'd0, 1'b0);
    check_all("ram_narrow", 16'h00CD, 1'b1, 4'd0, 1'b0, 8'd0);
    step(1'b1, 4'd6, 1'b0);
    check_all("ac_wide", 16'h5A5A, 1'b1, 4'd6, 1'b0, 8'd0);
    step(1'b1, 4'd7, 1'b0);
    check_all("instr_narrow", 16'h00EF, 1'b1, 4'd7, 1'b0, 8'd0);

    step(1'b1, 4'd1, 1'b0);
    check_all("b2b_pc", 16'hC0DE, 1'b1, 4'd1, 1'b0, 8'd0);
    step(1'b1, 4'd2, 1'b0);
    check_all("b2b_r1", 16'h2468, 1'b1, 4'd2, 1'b0, 8'd0);
    step(1'b1, 4'd3, 1'b0);
    check_all("b2b_r2", 16'h1357, 1'b1, 4'd3, 1'b0, 8'd0);
    step(1'b0, 4'd0, 1'b0);
    check_all("idle_hold", 16'h1357, 1'b0, 4'd3, 1'b0, 8'd0);

    step(1'b1, 4'd8, 1'b0);
    check_all("ar", 16'h0F0F, 1'b1, 4'd8, 1'b0, 8'd0);
    step(1'b1, 4'd12, 1'b0);
    check_all("invalid", 16'h0F0F, 1'b0, 4'd8, 1'b1, 8'd1);
    step(1'b1, 4'd12, 1'b1);
    check_all("clr_vs_inv", 16'h0F0F, 1'b0, 4'd8, 1'b1, 8'd1);

    for (int i = 0; i < 253; i++) step(1'b1, 4'd15, 1'b0);
    check("sat_254", 32'(ERR_CNT), 32'd254);
    for (int i = 0; i < 47; i++) step(1'b1, 4'd9, 1'b0);
    check_all("sat_hold", 16'h0F0F, 1'b0, 4'd8, 1'b1, 8'd255);

    step(1'b0, 4'd0, 1'b1);
    check_all("clr_alone", 16'h0F0F, 1'b0, 4'd8, 1'b0, 8'd0);
    step(1'b1, 4'd5, 1'b1);
    check_all("clr_with_load", 16'h1234, 1'b1, 4'd5, 1'b0, 8'd0);

    step(1'b1, 4'd4, 1'b0);
    check("tr_capture", 32'(BUS), 32'h1111);
    src[SRC_TR] = 16'h2222;
    step(1'b0, 4'd4, 1'b0);
    check_all("tr_no_resample", 16'h1111, 1'b0, 4'd4, 1'b0, 8'd0);

    step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd13, 1'b0);
    check_all("pre_reset", 16'h1234, 1'b0, 4'd5, 1'b1, 8'd1);
    #2 RST_N = 1'b0;
    #1 check_all("async_reset", 16'h0000, 1'b0, 4'd0, 1'b0, 8'd0);
    step(1'b1, 4'd2, 1'b0);
    check_all("in_reset", 16'h0000, 1'b0, 4'd0, 1'b0, 8'd0);
    RST_N = 1'b1;
    step(1'b1, 4'd2, 1'b0);
    check_all("post_reset", 16'h2468, 1'b1, 4'd2, 1'b0, 8'd0);
    step(1'b0, 4'd0, 1'b0);
    check_all("no_replay", 16'h2468, 1'b0, 4'd2, 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
